asg_rdr: RTL

// - Consumer end of the ASG burst address stream. Takes beats whose TDATA is a table address, TKEEP is address-enable and TLAST is end-of-run.
// - Reads the per-channel waveform table and emits a sample stream toward the DAC path.
// - Disabled beats (TKEEP=0) repeat the last sample. Implements full ready/valid backpressure.
//

---
 rtl/asg_rdr.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/asg_rdr.sv
// asg_rdr: ASG table reader, address beats in, waveform samples out.
// Optional S3 linear gain/offset stage enabled by macro ASG_RDR_LIN_EN.
module asg_rdr #(
  parameter int CWM = 14,
  parameter int DW  = 14,
  parameter int CWS = 32
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic [CWM-1:0] sti_tdata,
  input  logic           sti_tkeep,
  input  logic           sti_tlast,
  input  logic           sti_tvalid,
  output logic           sti_tready,
  output logic [DW-1:0]  sto_tdata,
  output logic           sto_tlast,
  output logic           sto_tvalid,
  input  logic           sto_tready,
  input  logic           bus_wen,
  input  logic           bus_ren,
  input  logic [CWM-1:0] bus_adr,
  input  logic [DW-1:0]  bus_wdt,
  output logic [DW-1:0]  bus_rdt,
  input  logic [DW-1:0]  cfg_mul,
  input  logic [DW-1:0]  cfg_sum,
  output logic [CWS-1:0] sts_cnt
);

  logic [DW-1:0] mem [0:(1<<CWM)-1];
  logic [DW-1:0] rdb_q;
  logic [DW-1:0] rdt_q;

  logic adv;
  logic xfer;

  logic           s1_vld_q, s1_vld_d;
  logic           s1_keep_q, s1_keep_d;
  logic           s1_last_q, s1_last_d;
  logic           s2_vld_q, s2_vld_d;
  logic           s2_last_q, s2_last_d;
  logic [DW-1:0]  s2_dat_q, s2_dat_d;
  logic [DW-1:0]  hold_q, hold_d;
  logic [CWS-1:0] cnt_q, cnt_d;

`ifdef ASG_RDR_LIN_EN
  localparam logic signed [2*DW:0] SMAX =
    {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] SMIN =
    {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic           s3_vld_q, s3_vld_d;
  logic           s3_last_q, s3_last_d;
  logic [DW-1:0]  s3_dat_q, s3_dat_d;
  logic signed [2*DW-1:0] lx, lm, prod, shf;
  logic signed [2*DW:0]   lsum;
  logic [DW-1:0]  sat;

  // Gain/offset math on the S2 sample, saturated to DW bits
  always_comb begin
    lx   = {{DW{s2_dat_q[DW-1]}}, s2_dat_q};
    lm   = {{DW{cfg_mul[DW-1]}}, cfg_mul};
    prod = lx * lm;
    shf  = prod >>> (DW-2);
    lsum = {shf[2*DW-1], shf}
         + {{(DW+1){cfg_sum[DW-1]}}, cfg_sum};
    if (lsum > SMAX)      sat = SMAX[DW-1:0];
    else if (lsum < SMIN) sat = SMIN[DW-1:0];
    else                  sat = lsum[DW-1:0];
  end

  assign sto_tvalid = s3_vld_q;
  assign sto_tlast  = s3_last_q;
  assign sto_tdata  = s3_dat_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_mul, cfg_sum};

  assign sto_tvalid = s2_vld_q;
  assign sto_tlast  = s2_last_q;
  assign sto_tdata  = s2_dat_q;
`endif

  assign adv        = sto_tready | ~sto_tvalid;
  assign sti_tready = adv;
  assign xfer       = sto_tvalid & sto_tready;
  assign bus_rdt    = rdt_q;
  assign sts_cnt    = cnt_q;

  // Bus port: write, and read returning pre-write data
  always_ff @(posedge ACLK) begin
    if (bus_wen) mem[bus_adr] <= bus_wdt;
  end

  // Bus read data register, cleared by reset
  always_ff @(posedge ACLK) begin
    if (ARESET)       rdt_q <= '0;
    else if (bus_ren) rdt_q <= mem[bus_adr];
  end

  // Stream port: read-only, enabled with the pipe advance
  always_ff @(posedge ACLK) begin
    if (adv) rdb_q <= mem[sti_tdata];
  end

  // Next-state for all pipe stages, hold register and counter
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_keep_d = s1_keep_q;
    s1_last_d = s1_last_q;
    s2_vld_d  = s2_vld_q;
    s2_last_d = s2_last_q;
    s2_dat_d  = s2_dat_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q + {{(CWS-1){1'b0}}, xfer};
`ifdef ASG_RDR_LIN_EN
    s3_vld_d  = s3_vld_q;
    s3_last_d = s3_last_q;
    s3_dat_d  = s3_dat_q;
`endif
    if (adv) begin
      s1_vld_d  = sti_tvalid;
      s1_keep_d = sti_tvalid & sti_tkeep;
      s1_last_d = sti_tvalid & sti_tlast;
      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_last_q;
      s2_dat_d  = s1_keep_q ? rdb_q : hold_q;
      if (s1_vld_q & s1_keep_q) hold_d = rdb_q;
`ifdef ASG_RDR_LIN_EN
      s3_vld_d  = s2_vld_q;
      s3_last_d = s2_last_q;
      s3_dat_d  = sat;
`endif
    end
  end

  // Pipe state registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_vld_q  <= 1'b0;
      s1_keep_q <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_dat_q  <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
`ifdef ASG_RDR_LIN_EN
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      s3_dat_q  <= '0;
`endif
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_keep_q <= s1_keep_d;
      s1_last_q <= s1_last_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      s2_dat_q  <= s2_dat_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
`ifdef ASG_RDR_LIN_EN
      s3_vld_q  <= s3_vld_d;
      s3_last_q <= s3_last_d;
      s3_dat_q  <= s3_dat_d;
`endif
    end
  end

endmodule
